// File: rtl/hash_word_loader_if.sv
// Word-loader bus: input word handshake, assembled-register output handshake and sync clear.
// The master drives the word source and consumer side. The slave is the loader itself.
interface hash_word_loader_if #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 16,
  parameter int IDX_W     = 4
);
  logic                        clear;
  logic                        in_valid;
  logic                        in_ready;
  logic [WORD_W-1:0]           in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [WORD_W*NUM_WORDS-1:0] hashed;
  logic [IDX_W-1:0]            wr_idx;
  logic [IDX_W:0]              word_count;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, hashed, wr_idx, word_count
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, hashed, wr_idx, word_count
  );
endinterface

// File: rtl/hash_word_loader.sv
// Assembles a WORD_W*NUM_WORDS register from NUM_WORDS handshaked words and holds it until drained.
// Define LOADER_MSW_FIRST_EN to make the first word land in the top slot, with wr_idx counting down.
module hash_word_loader #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 16,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  hash_word_loader_if.slave bus
);

  typedef enum logic {S_FILL, S_FULL} state_e;

`ifdef LOADER_MSW_FIRST_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(NUM_WORDS - 1);
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
`endif
  localparam logic [IDX_W:0] LAST_COUNT = (IDX_W+1)'(NUM_WORDS - 1);

  state_e                      state_q, state_d;
  logic [WORD_W*NUM_WORDS-1:0] hashed_q, hashed_d;
  logic [IDX_W-1:0]            wr_idx_q, wr_idx_d;
  logic [IDX_W:0]              count_q, count_d;
  logic [IDX_W-1:0]            wr_idx_step;

`ifdef LOADER_MSW_FIRST_EN
  assign wr_idx_step = wr_idx_q - 1'b1;
`else
  assign wr_idx_step = wr_idx_q + 1'b1;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    hashed_d = hashed_q;
    wr_idx_d = wr_idx_q;
    count_d  = count_q;

    if (bus.clear) begin
      // Clear wins over any accept or drain in the same cycle.
      state_d  = S_FILL;
      hashed_d = '0;
      wr_idx_d = FIRST_IDX;
      count_d  = '0;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (bus.in_valid) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
              if (wr_idx_q == IDX_W'(k)) hashed_d[k*WORD_W +: WORD_W] = bus.in_data;
            end
            count_d = count_q + 1'b1;
            // The last slot's index is held while full; it wraps only when draining back to FILL.
            if (count_q == LAST_COUNT) state_d = S_FULL;
            else                       wr_idx_d = wr_idx_step;
          end
        end
        S_FULL: begin
          if (bus.out_ready) begin
            state_d  = S_FILL;
            wr_idx_d = FIRST_IDX;
            count_d  = '0;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FILL;
      hashed_q <= '0;
      wr_idx_q <= FIRST_IDX;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      hashed_q <= hashed_d;
      wr_idx_q <= wr_idx_d;
      count_q  <= count_d;
    end
  end

  assign bus.in_ready   = (state_q == S_FILL);
  assign bus.out_valid  = (state_q == S_FULL);
  assign bus.hashed     = hashed_q;
  assign bus.wr_idx     = wr_idx_q;
  assign bus.word_count = count_q;

endmodule

// File: tb/tb_hash_word_loader.sv
// Directed bench for hash_word_loader covering fill, backpressure, gaps, clear and refill.
// It follows LOADER_MSW_FIRST_EN so that slot placement matches the build.
module tb_hash_word_loader;

  localparam int WORD_W = 16;
  localparam int NUM_WORDS = 16;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  logic [15:0] exp_words [16];

  hash_word_loader_if bus ();

  hash_word_loader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot that the n-th accepted word of a fill is written to.
  function automatic int pos(input int n);
`ifdef LOADER_MSW_FIRST_EN
    return NUM_WORDS - 1 - n;
`else
    return n;
`endif
  endfunction

  function automatic logic [255:0] model_hashed();
    logic [255:0] h;
    h = '0;
    for (int n = 0; n < NUM_WORDS; n++) h[pos(n)*WORD_W +: WORD_W] = exp_words[n];
    return h;
  endfunction

  // Called on a negedge: present a word, then return at the next negedge with in_valid still high.
  task automatic offer_word(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #12;
    tests++; if (bus.hashed !== 256'h0) begin fails++; $display("FAIL reset_hashed: got %h expected 0", bus.hashed); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    tests++; if (bus.word_count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus.word_count); end
    tests++; if (bus.wr_idx !== 4'(pos(0))) begin fails++; $display("FAIL reset_wr_idx: got %0d expected %0d", bus.wr_idx, pos(0)); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    // Load a few words, then pull reset mid-cycle and look before any clock edge.
    for (int k = 0; k < 5; k++) offer_word(16'h0700 + 16'(k));
    bus.in_valid = 1'b0;
    tests++; if (bus.word_count !== 5'd5) begin fails++; $display("FAIL prefill_count: got %0d expected 5", bus.word_count); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (bus.hashed !== 256'h0) begin fails++; $display("FAIL midfill_reset_hashed: got %h expected 0", bus.hashed); end
    tests++; if (bus.word_count !== 5'd0) begin fails++; $display("FAIL midfill_reset_count: got %0d expected 0", bus.word_count); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midfill_reset_out_valid: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int k = 0; k < NUM_WORDS; k++) begin
      exp_words[k] = 16'(k);
      offer_word(16'(k));
      tests++; if (bus.word_count !== 5'(k + 1)) begin fails++; $display("FAIL fill_count[%0d]: got %0d expected %0d", k, bus.word_count, k + 1); end
      tests++; if (bus.out_valid !== (k == NUM_WORDS - 1)) begin fails++; $display("FAIL fill_out_valid[%0d]: got %b", k, bus.out_valid); end
      if (k < NUM_WORDS - 1) begin
        tests++; if (bus.wr_idx !== 4'(pos(k + 1))) begin fails++; $display("FAIL fill_wr_idx[%0d]: got %0d expected %0d", k, bus.wr_idx, pos(k + 1)); end
      end
    end
    bus.in_valid = 1'b0;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready: got %b expected 0", bus.in_ready); end
`ifdef LOADER_MSW_FIRST_EN
    tests++; if (bus.hashed[255:240] !== 16'h0000) begin fails++; $display("FAIL fill_top_slot: got %h expected 0000", bus.hashed[255:240]); end
    tests++; if (bus.hashed[15:0] !== 16'h000F) begin fails++; $display("FAIL fill_bottom_slot: got %h expected 000f", bus.hashed[15:0]); end
`else
    tests++; if (bus.hashed[15:0] !== 16'h0000) begin fails++; $display("FAIL fill_bottom_slot: got %h expected 0000", bus.hashed[15:0]); end
    tests++; if (bus.hashed[255:240] !== 16'h000F) begin fails++; $display("FAIL fill_top_slot: got %h expected 000f", bus.hashed[255:240]); end
`endif
    tests++; if (bus.hashed !== model_hashed()) begin fails++; $display("FAIL fill_hashed: got %h expected %h", bus.hashed, model_hashed()); end
  endtask

  task automatic test_backpressure();
    logic [255:0] held;
    held = model_hashed();
    for (int c = 0; c < 5; c++) offer_word(16'hDEAD);
    bus.in_valid = 1'b0;
    tests++; if (bus.hashed !== held) begin fails++; $display("FAIL bp_hashed: got %h expected %h", bus.hashed, held); end
    tests++; if (bus.word_count !== 5'd16) begin fails++; $display("FAIL bp_count: got %0d expected 16", bus.word_count); end
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid: got %b expected 1", bus.out_valid); end
    drain();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL drain_out_valid: got %b expected 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL drain_in_ready: got %b expected 1", bus.in_ready); end
    tests++; if (bus.word_count !== 5'd0) begin fails++; $display("FAIL drain_count: got %0d expected 0", bus.word_count); end
    tests++; if (bus.wr_idx !== 4'(pos(0))) begin fails++; $display("FAIL drain_wr_idx: got %0d expected %0d", bus.wr_idx, pos(0)); end
    tests++; if (bus.hashed !== held) begin fails++; $display("FAIL drain_hashed: got %h expected %h", bus.hashed, held); end
  endtask

  task automatic test_gapped();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = (i % 2 == 0) ? 16'h0100 + 16'(n) : 16'hFFFF;
      if (i % 2 == 0) begin
        exp_words[n] = 16'h0100 + 16'(n);
        n++;
      end
      @(negedge clk);
      tests++; if (bus.word_count !== 5'(n)) begin fails++; $display("FAIL gap_count[%0d]: got %0d expected %0d", i, bus.word_count, n); end
      if (n < NUM_WORDS) begin
        tests++; if (bus.wr_idx !== 4'(pos(n))) begin fails++; $display("FAIL gap_wr_idx[%0d]: got %0d expected %0d", i, bus.wr_idx, pos(n)); end
      end
    end
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL gap_out_valid: got %b expected 1", bus.out_valid); end
    tests++; if (bus.hashed !== model_hashed()) begin fails++; $display("FAIL gap_hashed: got %h expected %h", bus.hashed, model_hashed()); end
    drain();
  endtask

  task automatic test_clear_collision();
    for (int k = 0; k < 7; k++) offer_word(16'h0200 + 16'(k));
    bus.clear   = 1'b1;
    bus.in_data = 16'hBEEF;
    @(negedge clk);
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    tests++; if (bus.hashed !== 256'h0) begin fails++; $display("FAIL clr_hashed: got %h expected 0", bus.hashed); end
    tests++; if (bus.word_count !== 5'd0) begin fails++; $display("FAIL clr_count: got %0d expected 0", bus.word_count); end
    tests++; if (bus.wr_idx !== 4'(pos(0))) begin fails++; $display("FAIL clr_wr_idx: got %0d expected %0d", bus.wr_idx, pos(0)); end
    for (int k = 0; k < NUM_WORDS; k++) begin
      exp_words[k] = 16'h0300 + 16'(k);
      offer_word(exp_words[k]);
    end
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL clr_refill_out_valid: got %b expected 1", bus.out_valid); end
    tests++; if (bus.hashed !== model_hashed()) begin fails++; $display("FAIL clr_refill_hashed: got %h expected %h", bus.hashed, model_hashed()); end
    // Clear while FULL drops the pending register.
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL clr_full_out_valid: got %b expected 0", bus.out_valid); end
    tests++; if (bus.hashed !== 256'h0) begin fails++; $display("FAIL clr_full_hashed: got %h expected 0", bus.hashed); end
  endtask

  task automatic test_refill();
    // Put distinct data in every slot, drain it, then overwrite with new words.
    for (int k = 0; k < NUM_WORDS; k++) offer_word(16'h5500 + 16'(k));
    drain();
    for (int k = 0; k < NUM_WORDS; k++) begin
      exp_words[k] = 16'hA000 + 16'(k);
      // out_ready is raised during the first half of the fill and must be ignored.
      bus.out_ready = (k < 8);
      offer_word(exp_words[k]);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL refill_out_valid: got %b expected 1", bus.out_valid); end
    tests++; if (bus.word_count !== 5'd16) begin fails++; $display("FAIL refill_count: got %0d expected 16", bus.word_count); end
    tests++; if (bus.hashed !== model_hashed()) begin fails++; $display("FAIL refill_hashed: got %h expected %h", bus.hashed, model_hashed()); end
    drain();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b1;
    idle_inputs();
    test_reset();
    test_fill();
    test_backpressure();
    test_gapped();
    test_clear_collision();
    test_refill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
